counter_seq_checker: RTL and testbench

- Sits directly downstream of the free-running 8-bit counter stage and consumes its counter value and zero flag.
- Tracks the value stream sample by sample and locks once it sees a run of consecutive +1 increments.
- Counts wrap-arounds and sequence errors, and flags any sample where the zero flag disagrees with the value.
- Serves as the on-chip self-check for counter register init and reset behaviour.

---
 rtl/counter_seq_checker.sv | 151 +++++++++++++++
 tb/tb_counter_seq_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// Sequence checker for an upstream 8-bit free-running counter and its zero flag.
// Latency: a sample accepted at edge N is reflected on every output just after edge N.
// Backpressure: none; samples are consumed whenever in_valid=1, and gaps hold all state.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   in_valid          - sample strobe
//   in_val/in_is_zero - counter value and zero flag from the upstream stage
//   clear             - synchronous soft clear (drops a same-cycle sample)
//   locked            - FSM is in LOCK
//   err_pulse         - one-cycle pulse per in-lock sequence error
//   err_count         - saturating in-lock sequence error count
//   wrap_count        - saturating in-lock wrap (max -> 0) count
//   last_bad          - value of the most recent in-lock sequence error
//   zero_flag_err     - sticky zero-flag inconsistency
module counter_seq_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_val,
  input  logic                  in_is_zero,
  input  logic                  clear,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      last_bad,
  output logic                  zero_flag_err
);

  localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [GOOD_W-1:0]       good, good_nxt;
  logic [WIDTH-1:0]        prev, prev_nxt;
  logic [ERR_CNT_W-1:0]    err_cnt_nxt;
  logic [WRAP_CNT_W-1:0]   wrap_cnt_nxt;
  logic [WIDTH-1:0]        last_bad_nxt;
  logic                    zf_err_nxt;
  logic                    err_pulse_nxt;

  logic [WIDTH-1:0]        prev_inc;
  logic                    match;
  logic                    zero_mismatch;

  // WIDTH-bit add: carry discarded so max -> 0 counts as a good increment.
  assign prev_inc      = prev + WIDTH'(1);
  assign match         = (in_val == prev_inc);
  assign zero_mismatch = (in_is_zero != (in_val == '0));

  // State is itself a register, so locked is a registered decode.
  assign locked = (state == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      good          <= '0;
      prev          <= '0;
      err_count     <= '0;
      wrap_count    <= '0;
      last_bad      <= '0;
      zero_flag_err <= 1'b0;
      err_pulse     <= 1'b0;
    end else begin
      state         <= state_nxt;
      good          <= good_nxt;
      prev          <= prev_nxt;
      err_count     <= err_cnt_nxt;
      wrap_count    <= wrap_cnt_nxt;
      last_bad      <= last_bad_nxt;
      zero_flag_err <= zf_err_nxt;
      err_pulse     <= err_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    good_nxt      = good;
    prev_nxt      = prev;
    err_cnt_nxt   = err_count;
    wrap_cnt_nxt  = wrap_count;
    last_bad_nxt  = last_bad;
    zf_err_nxt    = zero_flag_err;
    err_pulse_nxt = 1'b0;

    if (clear) begin
      // Clear wins over a same-cycle sample; that sample is discarded.
      state_nxt    = IDLE;
      good_nxt     = '0;
      prev_nxt     = '0;
      err_cnt_nxt  = '0;
      wrap_cnt_nxt = '0;
      last_bad_nxt = '0;
      zf_err_nxt   = 1'b0;
    end else if (in_valid) begin
      prev_nxt = in_val;
      if (zero_mismatch) begin
        zf_err_nxt = 1'b1;
      end
      unique case (state)
        IDLE: begin
          good_nxt  = '0;
          state_nxt = ACQ;
        end
        ACQ: begin
          if (match) begin
            if (good == GOOD_W'(LOCK_CNT - 1)) begin
              good_nxt  = GOOD_W'(LOCK_CNT);
              state_nxt = LOCK;
            end else begin
              good_nxt = good + GOOD_W'(1);
            end
          end else begin
            good_nxt = '0;
          end
        end
        LOCK: begin
          if (match) begin
            if ((in_val == '0) && (wrap_count != {WRAP_CNT_W{1'b1}})) begin
              wrap_cnt_nxt = wrap_count + WRAP_CNT_W'(1);
            end
          end else begin
            err_pulse_nxt = 1'b1;
            last_bad_nxt  = in_val;
            good_nxt      = '0;
            state_nxt     = ACQ;
            if (err_count != {ERR_CNT_W{1'b1}}) begin
              err_cnt_nxt = err_count + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          good_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: lock acquisition, wraps, in-lock errors,
// zero-flag check, soft clear, gaps, error-count saturation and async reset.
// Inputs change 1 time unit after each posedge; outputs are checked at that point.
module tb_counter_seq_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_val;
  logic        in_is_zero;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] wrap_count;
  logic [7:0]  last_bad;
  logic        zero_flag_err;

  int checks   = 0;
  int failures = 0;

  counter_seq_checker #(
    .WIDTH(8), .LOCK_CNT(4), .ERR_CNT_W(8), .WRAP_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val),
    .in_is_zero(in_is_zero), .clear(clear), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .wrap_count(wrap_count),
    .last_bad(last_bad), .zero_flag_err(zero_flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted sample with an explicit zero flag, then return just after the edge.
  task automatic send_raw(input logic [7:0] v, input logic z);
    in_valid   = 1'b1;
    in_val     = v;
    in_is_zero = z;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    send_raw(v, (v == 8'd0));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic soft_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_val     = 8'd0;
    in_is_zero = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_locked",     locked,        0);
    chk("rst_err_pulse",  err_pulse,     0);
    chk("rst_err_count",  err_count,     0);
    chk("rst_wrap_count", wrap_count,    0);
    chk("rst_last_bad",   last_bad,      0);
    chk("rst_zf_err",     zero_flag_err, 0);
    rst = 1'b0;
    idle_cycle();

    // 1: first sample enters ACQ, four matches lock.
    for (int i = 0; i < 4; i++) begin
      send(8'(i));
      chk("t1_not_locked", locked, 0);
    end
    send(8'd4);
    chk("t1_locked",    locked,    1);
    chk("t1_err_count", err_count, 0);

    // 2: in-lock wrap 255 -> 0 counted once, no errors.
    soft_clear();
    for (int i = 248; i <= 252; i++) send(8'(i));
    chk("t2_locked_252", locked, 1);
    v = 8'd252;
    for (int i = 0; i < 5; i++) begin
      v = v + 8'd1;
      send(v);
      chk("t2_no_pulse", err_pulse, 0);
      chk("t2_locked",   locked,    1);
    end
    chk("t2_wrap_count", wrap_count, 1);
    chk("t2_err_count",  err_count,  0);

    // 3: skip from 10 to 12 while locked.
    for (int i = 2; i <= 10; i++) send(8'(i));
    chk("t3_locked_10", locked, 1);
    send(8'd12);
    chk("t3_err_pulse", err_pulse, 1);
    chk("t3_err_count", err_count, 1);
    chk("t3_last_bad",  last_bad,  12);
    chk("t3_unlocked",  locked,    0);
    send(8'd13);
    chk("t3_pulse_drop", err_pulse, 0);
    chk("t3_acq_13",     locked,    0);
    send(8'd14);
    send(8'd15);
    chk("t3_acq_15",     locked,    0);
    send(8'd16);
    chk("t3_relocked",   locked,    1);
    chk("t3_err_count2", err_count, 1);

    // 4: zero flag wrong on value 0 (also an in-lock skip from 16).
    send_raw(8'd0, 1'b0);
    chk("t4_zf_set",    zero_flag_err, 1);
    chk("t4_err_count", err_count,     2);
    send(8'd1);
    send(8'd2);
    chk("t4_zf_sticky", zero_flag_err, 1);
    // Clear together with a valid sample: the sample must be dropped.
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_val     = 8'd7;
    in_is_zero = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("t4_clr_locked", locked,        0);
    chk("t4_clr_pulse",  err_pulse,     0);
    chk("t4_clr_errcnt", err_count,     0);
    chk("t4_clr_wrap",   wrap_count,    0);
    chk("t4_clr_lastbd", last_bad,      0);
    chk("t4_clr_zf",     zero_flag_err, 0);
    // 8 is the first tracked sample, so lock needs 9..12; had 7 been taken it would lock at 11.
    send(8'd8);
    chk("t4_8_no_pulse", err_pulse, 0);
    send(8'd9);
    send(8'd10);
    send(8'd11);
    chk("t4_11_unlocked", locked, 0);
    send(8'd12);
    chk("t4_12_locked",   locked,    1);
    chk("t4_12_errcnt",   err_count, 0);

    // 5: gaps keep lock; the unaccepted bad zero flag must be ignored.
    soft_clear();
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("t5_locked_5", locked, 1);
    in_val     = 8'd99;
    in_is_zero = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();
    chk("t5_gap_locked", locked,        1);
    chk("t5_gap_zf",     zero_flag_err, 0);
    send(8'd6);
    chk("t5_after_gap_pulse",  err_pulse, 0);
    chk("t5_after_gap_locked", locked,    1);
    chk("t5_after_gap_errcnt", err_count, 0);
    // 256 in-lock errors, relocking after each one.
    v = 8'd6;
    for (int i = 0; i < 256; i++) begin
      v = v + 8'd2;
      send(v);
      chk("t5_sat_pulse",  err_pulse, 1);
      chk("t5_sat_errcnt", err_count, (i + 1 > 255) ? 255 : i + 1);
      for (int k = 0; k < 4; k++) begin
        v = v + 8'd1;
        send(v);
      end
      chk("t5_sat_relock", locked, 1);
    end
    chk("t5_last_bad", last_bad, 8'(v - 8'd4));

    // Run in lock through a wrap so wrap_count is nonzero before reset.
    while (v != 8'd0) begin
      v = v + 8'd1;
      send(v);
    end
    chk("t6_pre_locked", locked,            1);
    chk("t6_pre_wrap",   (wrap_count != 0), 1);

    // 6: async reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("t6_locked",    locked,        0);
    chk("t6_err_count", err_count,     0);
    chk("t6_wrap",      wrap_count,    0);
    chk("t6_last_bad",  last_bad,      0);
    chk("t6_zf",        zero_flag_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'd20);
    chk("t6_restart_unlocked", locked, 0);
    send(8'd21);
    send(8'd22);
    send(8'd23);
    chk("t6_restart_acq", locked, 0);
    send(8'd24);
    chk("t6_restart_locked", locked,    1);
    chk("t6_restart_errcnt", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
